// File: rtl/rep_code_pkg.sv
// rtl/rep_code_pkg.sv - shared types, defaults and parity helper for the repetition-code link
package rep_code_pkg;

    localparam int DEFAULT_DATA_W = 8;
    localparam int DEFAULT_REP    = 3;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } rep_state_e;

    // Callers zero-extend their word; leading zeros do not change even parity.
    function automatic logic even_parity(input logic [63:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/rep_beat_ctr.sv
// rtl/rep_beat_ctr.sv - REP-cycle beat counter with terminal pulse, shared by tx and rx
module rep_beat_ctr #(
    parameter int REP = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic term_o
);

    localparam int CNT_W = $clog2(REP);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign term_o = en_i && (cnt_q == CNT_W'(REP - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = term_o ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/rep3_serial_tx.sv
// rtl/rep3_serial_tx.sv - LSB-first repetition-code serial transmitter; REP3_TX_PARITY_EN appends an even-parity bit
module rep3_serial_tx
    import rep_code_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int REP    = DEFAULT_REP
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              tx_bit,
    output logic              tx_valid,
    output logic              tx_first,
    output logic              busy
);

`ifdef REP3_TX_PARITY_EN
    localparam int NBITS = DATA_W + 1;
`else
    localparam int NBITS = DATA_W;
`endif
    localparam int BIT_W = $clog2(NBITS + 1);

    rep_state_e       state_q, state_d;
    logic [NBITS-1:0] shreg_q, shreg_d;
    logic [BIT_W-1:0] bit_idx_q, bit_idx_d;
    logic             tx_bit_q, tx_bit_d;
    logic             tx_valid_q, tx_valid_d;
    logic             tx_first_q, tx_first_d;
    logic             busy_q, busy_d;

    logic             rep_term;
    logic             last_beat;
    logic             accept;
    logic [NBITS-1:0] frame_word;

`ifdef REP3_TX_PARITY_EN
    assign frame_word = {even_parity(64'(in_data)), in_data};
`else
    assign frame_word = in_data;
`endif

    assign last_beat = (state_q == SEND) && rep_term && (bit_idx_q == BIT_W'(NBITS - 1));
    // Ready only when idle or on the final beat, so frames chain with no gap.
    assign in_ready  = rst_n && ((state_q == IDLE) || last_beat);
    assign accept    = in_valid && in_ready;

    rep_beat_ctr #(
        .REP(REP)
    ) u_beat_ctr (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (accept),
        .en_i   (state_q == SEND),
        .term_o (rep_term)
    );

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        bit_idx_d  = bit_idx_q;
        tx_bit_d   = tx_bit_q;
        tx_valid_d = tx_valid_q;
        tx_first_d = tx_first_q;
        busy_d     = busy_q;
        if (accept) begin
            state_d    = SEND;
            shreg_d    = frame_word;
            bit_idx_d  = '0;
            tx_bit_d   = frame_word[0];
            tx_valid_d = 1'b1;
            tx_first_d = 1'b1;
            busy_d     = 1'b1;
        end else if (last_beat) begin
            state_d    = IDLE;
            shreg_d    = '0;
            bit_idx_d  = '0;
            tx_bit_d   = 1'b0;
            tx_valid_d = 1'b0;
            tx_first_d = 1'b0;
            busy_d     = 1'b0;
        end else if (state_q == SEND) begin
            tx_first_d = 1'b0;
            if (rep_term) begin
                bit_idx_d = bit_idx_q + BIT_W'(1);
                shreg_d   = shreg_q >> 1;
                tx_bit_d  = shreg_d[0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            bit_idx_q  <= '0;
            tx_bit_q   <= 1'b0;
            tx_valid_q <= 1'b0;
            tx_first_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            bit_idx_q  <= bit_idx_d;
            tx_bit_q   <= tx_bit_d;
            tx_valid_q <= tx_valid_d;
            tx_first_q <= tx_first_d;
            busy_q     <= busy_d;
        end
    end

    assign tx_bit   = tx_bit_q;
    assign tx_valid = tx_valid_q;
    assign tx_first = tx_first_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_rep3_serial_tx.sv
// tb/tb_rep3_serial_tx.sv - directed and majority-vote loopback bench for rep3_serial_tx
module tb_rep3_serial_tx;

    localparam int DATA_W = 8;
    localparam int REP    = 3;
`ifdef REP3_TX_PARITY_EN
    localparam int NBITS = DATA_W + 1;
`else
    localparam int NBITS = DATA_W;
`endif
    localparam int NBEATS = NBITS * REP;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic              tx_bit;
    logic              tx_valid;
    logic              tx_first;
    logic              busy;

    int n_vec     = 0;
    int n_miscmp  = 0;

    always #5 clk = ~clk;

    rep3_serial_tx #(
        .DATA_W(DATA_W),
        .REP   (REP)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .tx_bit   (tx_bit),
        .tx_valid (tx_valid),
        .tx_first (tx_first),
        .busy     (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miscmp++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Packed view: {tx_valid, busy, tx_first, in_ready, tx_bit}
    function automatic logic [4:0] outs();
        return {tx_valid, busy, tx_first, in_ready, tx_bit};
    endfunction

    function automatic logic [31:0] frame_bits(input logic [7:0] w);
`ifdef REP3_TX_PARITY_EN
        return {23'd0, ^w, w};
`else
        return {24'd0, w};
`endif
    endfunction

    task automatic start(input logic [7:0] w);
        in_valid = 1'b1;
        in_data  = w;
        check($sformatf("accept_ready_%02h", w), 32'(in_ready), 32'd1);
        @(posedge clk);
    endtask

    // mode 0: drop in_valid; 1: hold nxt; 2: garbage data with valid high, nxt on last beat
    task automatic frame(input logic [7:0] w, input int mode, input logic [7:0] nxt, input int nb);
        logic [31:0] fb;
        logic [4:0]  exp;
        fb = frame_bits(w);
        for (int b = 1; b <= nb; b++) begin
            @(negedge clk);
            exp = {1'b1, 1'b1, (b == 1), (b == NBEATS), fb[(b-1)/REP]};
            check($sformatf("beat_%02h_%0d", w, b), 32'(outs()), 32'(exp));
            case (mode)
                0: in_valid = 1'b0;
                1: begin
                    in_valid = 1'b1;
                    in_data  = nxt;
                end
                default: begin
                    in_valid = 1'b1;
                    in_data  = (b == NBEATS) ? nxt : 8'($urandom);
                end
            endcase
        end
    endtask

    initial begin
        logic [7:0]  w;
        logic [7:0]  nxt;
        logic [31:0] rec;
        int          ones;
        int          flip;

        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        repeat (2) @(negedge clk);
        check("reset_outs", 32'(outs()), 32'(5'b00000));
        rst_n = 1'b1;
        #1;
        check("post_reset_idle", 32'(outs()), 32'(5'b00010));

        start(8'hA5);
        frame(8'hA5, 0, 8'h00, NBEATS);
        @(negedge clk);
        check("idle_after_a5", 32'(outs()), 32'(5'b00010));

        start(8'hFF);
        frame(8'hFF, 1, 8'h00, NBEATS);
        frame(8'h00, 0, 8'h00, NBEATS);
        @(negedge clk);
        check("idle_after_b2b", 32'(outs()), 32'(5'b00010));

        start(8'h5A);
        frame(8'h5A, 2, 8'hC3, NBEATS);
        frame(8'hC3, 0, 8'h00, NBEATS);
        @(negedge clk);
        check("idle_after_hold", 32'(outs()), 32'(5'b00010));

        start(8'h3C);
        frame(8'h3C, 0, 8'h00, 9);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_frame_reset", 32'(outs()), 32'(5'b00000));
        @(negedge clk);
        check("reset_held", 32'(outs()), 32'(5'b00000));
        rst_n = 1'b1;
        #1;
        check("post_abort_idle", 32'(outs()), 32'(5'b00010));
        start(8'h01);
        frame(8'h01, 0, 8'h00, NBEATS);
        @(negedge clk);
        check("idle_after_01", 32'(outs()), 32'(5'b00010));

        w = 8'($urandom);
        start(w);
        for (int i = 0; i < 1000; i++) begin
            nxt = 8'($urandom);
            rec = '0;
            for (int j = 0; j < NBITS; j++) begin
                ones = 0;
                flip = int'($urandom_range(0, REP - 1));
                for (int r = 0; r < REP; r++) begin
                    @(negedge clk);
                    ones += int'(tx_bit ^ (r == flip));
                    if (j == NBITS - 1 && r == REP - 1) begin
                        in_valid = (i < 999);
                        in_data  = nxt;
                    end else begin
                        in_valid = 1'b0;
                    end
                end
                rec[j] = (ones > REP / 2);
            end
            check($sformatf("loopback_%0d", i), rec, frame_bits(w));
            w = nxt;
        end
        @(negedge clk);
        check("idle_after_loopback", 32'(outs()), 32'(5'b00010));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule

// File: doc/rep3_serial_tx.md
Name: rep3_serial_tx

Overview:
- Serial transmitter for the repetition-code link.
- Accepts a parallel data word over a valid/ready handshake. Shifts it out LSB first, holding each bit for REP consecutive cycles.
- The far end's majority voter recovers each bit from any REP-cycle group, even when a minority of beats is corrupted.
- Sits between the word-level producer and the single-wire link driver.

Parameters:
- DATA_W, 8, data word width in bits; must be >= 1.
- REP, 3, cycles each bit is repeated; odd, >= 3.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  DATA_W  word to transmit; sampled on acceptance.
- in_valid  input  1  producer has a word.
- in_ready  output  1  transmitter can accept a word this cycle.
- tx_bit  output  1  current line bit (registered).
- tx_valid  output  1  tx_bit is a valid beat (registered).
- tx_first  output  1  first beat of a frame (registered).
- busy  output  1  frame in progress (registered).

Behaviour:
- Reset, while rst_n is low:
  - tx_bit=0, tx_valid=0, tx_first=0, busy=0.
  - in_ready forced 0.
  - state=IDLE; shift register and counters cleared.
- States: IDLE and SEND.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready at edge T: latch in_data, go to SEND.
  - From T+1: tx_valid=1, tx_first=1, busy=1, tx_bit=in_data[0].
- SEND:
  - Beat counter rep_cnt runs 0..REP-1.
  - Bit index bit_idx runs 0..NBITS-1, where NBITS=DATA_W (DATA_W+1 with parity).
  - tx_bit holds the current bit for REP cycles, then advances to the next bit.
  - tx_first is high only on beat 0 of bit 0.
  - Frame length is NBITS*REP cycles.
- Last beat (bit_idx=NBITS-1, rep_cnt=REP-1):
  - in_ready=1 combinationally. This is the only SEND cycle where in_ready is 1.
  - If a word is accepted, the next frame starts the following cycle with no gap, and tx_first=1 again.
  - Otherwise: return to IDLE; tx_valid=0, busy=0, tx_bit=0.
- in_valid during any other SEND cycle is ignored. The producer holds the word until accepted; in_data changes while not accepted have no effect.
- Latency: 1 cycle from acceptance to the first beat.
- Sustained throughput: one word per NBITS*REP cycles.
- Reset mid-frame: outputs drop to reset values immediately (asynchronous). The partial frame is abandoned, never resumed. After rst_n rises, in_ready=1 on the first cycle.
- Widths:
  - rep_cnt is $clog2(REP) bits.
  - bit_idx is $clog2(NBITS+1) bits.
  - Counters never wrap past their terminal values; they reload to 0 at terminal.

Optional Feature:
- Macro REP3_TX_PARITY_EN.
- Defined:
  - An even-parity bit (XOR of all DATA_W data bits) is appended after the MSB and repeated REP times.
  - NBITS=DATA_W+1.
  - Parity is computed at acceptance and stored with the word.
- Undefined: no parity logic or storage; NBITS=DATA_W.

Decomposition:
- Shared package rep_code_pkg:
  - state enum (IDLE, SEND)
  - default DATA_W and REP constants
  - helper function for even parity
- Receiver and transmitter both import it.
- One sub-module, rep_beat_ctr:
  - parameterised REP-cycle beat counter
  - outputs a terminal pulse
  - reused by the matching receiver.

Test Plan:
- DATA_W=8, REP=3, send 0xA5 →
  - tx_bit sequence 111 000 111 000 000 111 000 111 over 24 cycles starting one cycle after acceptance.
  - tx_first high only on cycle 1.
  - in_ready high only on beat 24.
- Back-to-back 0xFF then 0x00, in_valid held high →
  - 24 ones then 24 zeros, tx_valid continuous, no idle gap.
  - Second tx_first on beat 25.
- in_valid held high with a changing in_data during beats 1–23 of a frame →
  - no extra acceptance.
  - Frame unchanged; the next word is taken only at beat 24.
- rst_n driven low at beat 10 of 0x3C →
  - tx_valid, busy, tx_bit go 0 immediately; in_ready 0 during reset.
  - After release, in_ready=1; next word 0x01 produces a clean 111 then 21 zeros.
- With REP3_TX_PARITY_EN, send 0x07 →
  - 27 beats: 111 111 111 then 15 zeros, then parity 111.
  - Without the macro: 24 beats, no parity group.
- Loopback of random words through a majority voter, with one beat per 3-beat group flipped at random →
  - every recovered word equals the sent word across 1000 words.
